// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART echo driver: bus addresses, FSM states,
// baud table and the divisor computation.
package spart_pkg;

   typedef enum logic [1:0] {
      BUF  = 2'b00,
      STAT = 2'b01,
      DBL  = 2'b10,
      DBH  = 2'b11
   } ioaddr_t;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RX_RD,
      TX_WR
   } drv_state_t;

   localparam int unsigned BAUD_4800  = 4800;
   localparam int unsigned BAUD_9600  = 9600;
   localparam int unsigned BAUD_19200 = 19200;
   localparam int unsigned BAUD_38400 = 38400;

   // SPART oversamples by 16; the divisor register holds the terminal count.
   function automatic logic [15:0] divisor(input int unsigned clk_hz, input int unsigned baud);
      return 16'((clk_hz / (16 * baud)) - 1);
   endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// SPART I/O bus control and status signals. The data bus stays a plain inout port
// on the driver so the tristate resolves at module boundaries.
interface spart_echo_driver_if;
   import spart_pkg::*;

   logic    iocs;
   logic    iorw;
   ioaddr_t ioaddr;
   logic    rda;
   logic    tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);

endinterface

// File: rtl/spart_echo_driver_fifo.sv
// Show-ahead synchronous FIFO holding received characters until the transmitter is ready.
// The occupancy count separates full from empty, so the pointers wrap freely.
module echo_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wp, r_rp;
   logic [AW:0]       r_cnt;
   logic              w_push, w_pop;

   assign full   = (r_cnt == (AW+1)'(FIFO_DEPTH));
   assign empty  = (r_cnt == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign rdata  = r_mem[r_rp];
   assign count  = r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= wdata;
   end

endmodule

// File: rtl/spart_echo_driver.sv
// SPART bus master: programs the baud divisor from baud_sel, then echoes every received
// character back out through a small FIFO, reprogramming whenever baud_sel changes.
module spart_echo_driver
   import spart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int DATA_W          = 8,
   parameter int FIFO_DEPTH      = 4,
   parameter int CASE_SWAP       = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [1:0]                      baud_sel,
   spart_echo_driver_if.master             bus,
   inout  wire  [DATA_W-1:0]               databus,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam logic [15:0] DIV_TBL [4] = '{
      divisor(CLK_HZ, BAUD_4800), divisor(CLK_HZ, BAUD_9600),
      divisor(CLK_HZ, BAUD_19200), divisor(CLK_HZ, BAUD_38400)
   };

   drv_state_t        r_state, w_nxt;
   logic [1:0]        r_baud_sel;
   logic              w_recap;
   logic              w_iocs, w_iorw;
   ioaddr_t           w_addr;
   logic [DATA_W-1:0] w_wdata, w_head, w_rx;
   logic              w_full, w_empty;
   logic [15:0]       w_div;

   function automatic logic [DATA_W-1:0] swap_case(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r = d;
      logic [7:0]        b = d[7:0];
      if (CASE_SWAP != 0 && ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)))
         r[5] = ~r[5];
      return r;
   endfunction

   assign w_div = DIV_TBL[r_baud_sel];
   assign w_rx  = swap_case(databus);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= CFG_LO;
         r_baud_sel <= baud_sel;
      end else begin
         r_state <= w_nxt;
         if (w_recap) r_baud_sel <= baud_sel;
      end
   end

   always_comb begin
      w_nxt   = r_state;
      w_iocs  = 1'b0;
      w_iorw  = 1'b1;
      w_addr  = BUF;
      w_wdata = '0;
      w_recap = 1'b0;
      case (r_state)
         CFG_LO: begin
            w_iocs  = 1'b1;
            w_iorw  = 1'b0;
            w_addr  = DBL;
            w_wdata = DATA_W'(w_div[7:0]);
            w_nxt   = CFG_HI;
         end
         CFG_HI: begin
            w_iocs  = 1'b1;
            w_iorw  = 1'b0;
            w_addr  = DBH;
            w_wdata = DATA_W'(w_div[15:8]);
            w_nxt   = IDLE;
         end
         IDLE: begin
            if (baud_sel != r_baud_sel) begin
               w_recap = 1'b1;
               w_nxt   = CFG_LO;
            end else if (bus.rda && !w_full) begin
               w_nxt = RX_RD;
            end else if (bus.tbr && !w_empty) begin
               w_nxt = TX_WR;
            end
         end
         RX_RD: begin
            w_iocs = 1'b1;
            w_nxt  = IDLE;
         end
         TX_WR: begin
            w_iocs  = 1'b1;
            w_iorw  = 1'b0;
            w_wdata = w_head;
            w_nxt   = IDLE;
         end
         default: w_nxt = CFG_LO;
      endcase
   end

   // Gating with rst makes a mid-access reset release the bus without waiting for a clock.
   assign bus.iocs   = w_iocs & rst;
   assign bus.iorw   = w_iorw | ~rst;
   assign bus.ioaddr = rst ? w_addr : BUF;
   assign databus    = (w_iocs && !w_iorw && rst) ? w_wdata : 'z;

   echo_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_state == RX_RD),
      .pop   (r_state == TX_WR),
      .wdata (w_rx),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: a SPART model per DUT feeds receive bytes and logs bus writes;
// expected writes are queued as stimulus is driven and compared as the DUT produces them.
module tb_spart_echo_driver;
   import spart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] baud_sel0 = 2'b01;
   logic [1:0] baud_sel1 = 2'b00;
   logic       tbr0 = 1'b0, tbr1 = 1'b1;
   wire  [7:0] db0, db1;
   logic [2:0] cnt0, cnt1;

   logic [7:0] rx_mem0 [64];
   logic [7:0] rx_mem1 [64];
   logic [5:0] rx_wr0 = '0, rx_rd0 = '0, rx_wr1 = '0, rx_rd1 = '0;
   logic [9:0] wr_q0[$], wr_q1[$], exp_q[$];
   int         n_tests = 0, n_fail = 0;

   spart_echo_driver_if bus0();
   spart_echo_driver_if bus1();

   spart_echo_driver #(.CLK_HZ(50_000_000), .DATA_W(8), .FIFO_DEPTH(4), .CASE_SWAP(0)) dut0 (
      .clk(clk), .rst(rst), .baud_sel(baud_sel0), .bus(bus0), .databus(db0), .fifo_count(cnt0));
   spart_echo_driver #(.CLK_HZ(50_000_000), .DATA_W(8), .FIFO_DEPTH(4), .CASE_SWAP(1)) dut1 (
      .clk(clk), .rst(rst), .baud_sel(baud_sel1), .bus(bus1), .databus(db1), .fifo_count(cnt1));

   always #5 clk = ~clk;

   // SPART models: rda while bytes are pending, read data presented during a read access.
   assign bus0.rda = (rx_wr0 != rx_rd0);
   assign bus1.rda = (rx_wr1 != rx_rd1);
   assign bus0.tbr = tbr0;
   assign bus1.tbr = tbr1;
   assign db0 = (bus0.iocs && bus0.iorw) ? rx_mem0[rx_rd0] : 8'hzz;
   assign db1 = (bus1.iocs && bus1.iorw) ? rx_mem1[rx_rd1] : 8'hzz;

   always @(posedge clk) begin
      if (bus0.iocs && !bus0.iorw) wr_q0.push_back({bus0.ioaddr, db0});
      if (bus0.iocs && bus0.iorw && bus0.rda) rx_rd0 <= rx_rd0 + 6'd1;
      if (bus1.iocs && !bus1.iorw) wr_q1.push_back({bus1.ioaddr, db1});
      if (bus1.iocs && bus1.iorw && bus1.rda) rx_rd1 <= rx_rd1 + 6'd1;
   end

   task automatic push_rx(input int which, input logic [7:0] b);
      if (which == 0) begin
         rx_mem0[rx_wr0] = b;
         rx_wr0 = rx_wr0 + 6'd1;
      end else begin
         rx_mem1[rx_wr1] = b;
         rx_wr1 = rx_wr1 + 6'd1;
      end
   endtask

   task automatic wait_wr(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if ((which == 0 ? wr_q0.size() : wr_q1.size()) > 0) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_cnt0(input logic [2:0] want);
      for (int i = 0; i < 100 && cnt0 != want; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      bit ok; logic [9:0] exp, got;
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b0 || bus0.iorw !== 1'b1 || bus0.ioaddr !== BUF || cnt0 !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: iocs=%b iorw=%b ioaddr=%b cnt=%0d required 0 1 00 0",
                  bus0.iocs, bus0.iorw, bus0.ioaddr, cnt0);
      end
      exp_q.push_back({DBL, 8'h44});
      exp_q.push_back({DBH, 8'h01});
      rst = 1'b1;
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL reset_cfg: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL reset_cfg: got %h required %h", got, exp); end
         end
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b0) begin
         n_fail++; $display("FAIL idle_iocs: got %b required 0", bus0.iocs);
      end
   endtask

   task automatic test_echo;
      bit ok; logic [9:0] exp, got;
      tbr0 = 1'b1;
      push_rx(0, 8'h41); exp_q.push_back({BUF, 8'h41});
      push_rx(0, 8'h31); exp_q.push_back({BUF, 8'h31});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL echo: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL echo: got %h required %h", got, exp); end
         end
      end
   endtask

   task automatic test_fifo_full;
      bit ok; logic [9:0] exp, got;
      tbr0 = 1'b0;
      for (int i = 1; i <= 6; i++) push_rx(0, 8'(i));
      repeat (30) @(negedge clk);
      n_tests++;
      if (cnt0 !== 3'd4 || (rx_wr0 - rx_rd0) !== 6'd2) begin
         n_fail++;
         $display("FAIL fifo_full: count=%0d pending=%0d required 4 2", cnt0, rx_wr0 - rx_rd0);
      end
      tbr0 = 1'b1;
      for (int i = 1; i <= 6; i++) exp_q.push_back({BUF, 8'(i)});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL fifo_order: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL fifo_order: got %h required %h", got, exp); end
         end
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL fifo_drain: count=%0d required 0", cnt0); end
   endtask

   task automatic test_priority;
      bit ok; logic [9:0] exp, got;
      tbr0 = 1'b0;
      push_rx(0, 8'h10);
      wait_cnt0(3'd1);
      push_rx(0, 8'h11);
      tbr0 = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b1 || bus0.iorw !== 1'b1) begin
         n_fail++; $display("FAIL prio_rx_first: iocs=%b iorw=%b required 1 1", bus0.iocs, bus0.iorw);
      end
      @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b0) begin n_fail++; $display("FAIL prio_idle: iocs=%b required 0", bus0.iocs); end
      @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b1 || bus0.iorw !== 1'b0 || db0 !== 8'h10) begin
         n_fail++;
         $display("FAIL prio_tx_next: iocs=%b iorw=%b data=%h required 1 0 10", bus0.iocs, bus0.iorw, db0);
      end
      exp_q.push_back({BUF, 8'h10});
      exp_q.push_back({BUF, 8'h11});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL prio_wr: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL prio_wr: got %h required %h", got, exp); end
         end
      end
   endtask

   task automatic test_baud_change;
      bit ok; logic [9:0] exp, got;
      tbr0 = 1'b0;
      push_rx(0, 8'h20);
      push_rx(0, 8'h21);
      wait_cnt0(3'd2);
      baud_sel0 = 2'b11;
      exp_q.push_back({DBL, 8'h50});
      exp_q.push_back({DBH, 8'h00});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL baud_cfg: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL baud_cfg: got %h required %h", got, exp); end
         end
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL baud_keep: count=%0d required 2", cnt0); end
      tbr0 = 1'b1;
      exp_q.push_back({BUF, 8'h20});
      exp_q.push_back({BUF, 8'h21});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL baud_resume: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL baud_resume: got %h required %h", got, exp); end
         end
      end
   endtask

   task automatic test_reset_mid_tx;
      bit ok; logic [9:0] exp, got;
      tbr0 = 1'b0;
      push_rx(0, 8'h33);
      wait_cnt0(3'd1);
      tbr0 = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus0.iocs !== 1'b1 || bus0.iorw !== 1'b0) begin
         n_fail++; $display("FAIL midrst_tx: iocs=%b iorw=%b required 1 0", bus0.iocs, bus0.iorw);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (bus0.iocs !== 1'b0 || bus0.iorw !== 1'b1 || cnt0 !== 3'd0) begin
         n_fail++;
         $display("FAIL midrst_drop: iocs=%b iorw=%b count=%0d required 0 1 0", bus0.iocs, bus0.iorw, cnt0);
      end
      tbr0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back({DBL, 8'h50});
      exp_q.push_back({DBH, 8'h00});
      while (exp_q.size() > 0) begin
         wait_wr(0, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL midrst_cfg: timeout required %h", exp); end
         else begin
            got = wr_q0.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL midrst_cfg: got %h required %h", got, exp); end
         end
      end
      tbr0 = 1'b1;
      repeat (6) @(negedge clk);
      n_tests++;
      if (wr_q0.size() != 0) begin
         n_fail++; $display("FAIL midrst_nolost: extra writes=%0d required 0", wr_q0.size());
      end
   endtask

   task automatic test_case_swap;
      bit ok; logic [9:0] exp, got;
      logic [7:0] in_b  [6] = '{8'h41, 8'h31, 8'h7A, 8'h5B, 8'h60, 8'h40};
      logic [7:0] out_b [6] = '{8'h61, 8'h31, 8'h5A, 8'h5B, 8'h60, 8'h40};
      repeat (4) @(negedge clk);
      wr_q1.delete();
      for (int i = 0; i < 6; i++) begin
         push_rx(1, in_b[i]);
         exp_q.push_back({BUF, out_b[i]});
      end
      while (exp_q.size() > 0) begin
         wait_wr(1, ok); exp = exp_q.pop_front(); n_tests++;
         if (!ok) begin n_fail++; $display("FAIL case_swap: timeout required %h", exp); end
         else begin
            got = wr_q1.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL case_swap: got %h required %h", got, exp); end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_echo();
      test_fifo_full();
      test_priority();
      test_baud_change();
      test_reset_mid_tx();
      test_case_swap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
